esl_jtag_tap_master: RTL and testbench
======================================

ESL_JTAG_TAP_MASTER -- requirements
Module: esl_jtag_tap_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset (clk, reset_n).
REQ-002 Parameter CLK_DIV, default 4: TCK half-period in clk cycles; legal range 2..255.
REQ-003 Parameter MAX_LEN, default 38: maximum scan length in bits.
REQ-004 clk  in  1  system clock.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer when both are high on a clk edge.
REQ-007 cmd_ir  in  1  1 = IR scan, 0 = DR scan.
REQ-008 cmd_tlr  in  1  1 = Test-Logic-Reset sequence only; cmd_ir, cmd_len and cmd_data are ignored.
REQ-009 cmd_len  in  6  scan length in bits.
REQ-010 cmd_data  in  38  TDI bits, shifted LSB first.
REQ-011 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-012 rsp_data  out  38  captured TDO bits, right-aligned, with unused upper bits 0.
REQ-013 tck, tms, tdi  out  1 each  JTAG pins driven to the target.
REQ-014 tdo  in  1  JTAG pin from the target.
REQ-015 busy  out  1  high while a TAP sequence is in progress.

Function
REQ-016 The block SHALL generate TCK from clk, with each TCK cycle lasting 2*CLK_DIV clk cycles and a low phase followed by a high phase.
REQ-017 tms and tdi SHALL change only in the clk cycle after a tck falling edge; tdo SHALL be sampled in the clk cycle of the tck rising edge.
REQ-018 The FSM states SHALL be: INIT_TLR, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, RSP.
- INIT_TLR drives 5 TCK cycles with TMS=1, then 1 TCK cycle with TMS=0.
REQ-019 After reset, the block SHALL run INIT_TLR before raising cmd_ready.
REQ-020 A DR scan SHALL drive the per-TCK TMS sequence 1, 0, 0, then len-1 cycles of 0, then 1, 1, 0, and end in IDLE.
REQ-021 An IR scan SHALL drive the same sequence with an extra leading 1 (1, 1, 0, 0, ...).
REQ-022 On the last shifted bit, the block SHALL drive TMS=1 (entering Exit1) and still shift and capture that bit.
REQ-023 Bit i of rsp_data SHALL be the tdo value captured during shift bit i.
REQ-024 cmd_tlr SHALL run the INIT_TLR sequence and return rsp_data=0.
REQ-025 cmd_len=0 SHALL produce no TCK activity and return rsp_data=0 one cycle after acceptance.
REQ-026 cmd_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-027 cmd_ready SHALL be high only in IDLE with rsp_valid low; commands offered while busy SHALL be held off.
REQ-028 rsp_valid SHALL rise in the clk cycle after the Run-Test/Idle TCK cycle completes, and SHALL hold with rsp_data stable until rsp_ready is high.
REQ-029 tck SHALL be 0 whenever the TAP sequencer is idle; the divider restarts on command acceptance.
REQ-030 busy SHALL be high from command acceptance (or reset release) until the return to IDLE, and low in RSP.

Reset
REQ-031 While reset_n is low at a clk edge, the block SHALL drive tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0 and busy=1, and SHALL clear the divider and bit counter.
REQ-032 A reset asserted mid-scan SHALL abandon the scan with no response; INIT_TLR after release resynchronises the target TAP.

Configuration
REQ-033 Macro ESL_JTAG_MASTER_TRST_EN SHALL select the optional trst_n feature.
- Defined: adds output port trst_n, driven low during reset, during INIT_TLR and during cmd_tlr sequences, and high otherwise.
- Undefined: the port is absent and TLR uses the TMS sequence only.

Structure
REQ-034 Package esl_jtag_pkg SHALL hold the FSM state enum, MAX_LEN_C = 38, the TLR_CYCLES_C = 5 constant and the command struct.
REQ-035 Sub-module esl_jtag_tck_gen SHALL hold the divider and emit the tck, rise_stb and fall_stb strobes.

Verification
REQ-036 Reset release -> exactly 6 TCK cycles with TMS 1,1,1,1,1,0; cmd_ready rises afterward; tck period = 8 clk cycles.
REQ-037 DR scan, len=32, data=0x12345678, target model looping tdi->tdo with a 1-bit register -> rsp_data = (0x12345678<<1)|initial_bit, masked to 32 bits; TMS trace 1,0,0,0x31,1,1,0.
REQ-038 IR scan, len=2, data=2'b10, tdo tied 1 -> TMS 1,1,0,0,0,1,1,0; tdi bits 0 then 1; rsp_data=0x3.
REQ-039 rsp_ready held low for 20 cycles, second command offered -> rsp_valid and rsp_data stable, cmd_ready=0, no TCK edges until the handshake.
REQ-040 reset_n low at shift bit 10 of a len=38 scan -> outputs at reset values next edge, no rsp_valid, INIT_TLR rerun.
REQ-041 len=0 and len=45 -> immediate zero response; 38 bits shifted respectively.

Source files
------------

// File: rtl/esl_jtag_pkg.sv
// Shared types and constants for the JTAG TAP master.
// Optional trst_n output is enabled by defining ESL_JTAG_MASTER_TRST_EN.
package esl_jtag_pkg;

    localparam int MAX_LEN_C    = 38;
    localparam int TLR_CYCLES_C = 5;

    typedef enum logic [3:0] {
        INIT_TLR,
        IDLE,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE,
        RUN,
        RSP
    } state_t;

    typedef struct packed {
        logic       ir;
        logic       tlr;
        logic [5:0] len;
    } cmd_t;

endpackage

// File: rtl/esl_jtag_tck_gen.sv
// TCK divider: low phase then high phase, CLK_DIV clk cycles each.
// Strobes are high in the first clk cycle after each tck edge.
module esl_jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            cnt      <= '0;
            tck      <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            rise_stb <= wrap && !tck;
            fall_stb <= wrap && tck;
            if (wrap) begin
                cnt <= '0;
                tck <= ~tck;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/esl_jtag_tap_master.sv
// JTAG TAP master: TLR, IR and DR scans driven from a command handshake.
// Define ESL_JTAG_MASTER_TRST_EN to add the trst_n output.
module esl_jtag_tap_master
    import esl_jtag_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = MAX_LEN_C
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic               cmd_tlr,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
`ifdef ESL_JTAG_MASTER_TRST_EN
    output logic               trst_n,
`endif
    output logic               busy
);

    state_t             state, state_d;
    cmd_t               cmd_q;
    logic [MAX_LEN-1:0] dat_q, cap_q;
    logic [5:0]         cnt, cnt_d, len_c;
    logic               tms_d, tdi_d, accept;
    logic               rise_stb, fall_stb, last_bit;

    assign len_c     = (cmd_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : cmd_len;
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign busy      = (state != IDLE) && (state != RSP);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_data  = cap_q;
    assign last_bit  = (cnt == cmd_q.len - 6'd1);

`ifdef ESL_JTAG_MASTER_TRST_EN
    assign trst_n = reset_n && (state != INIT_TLR);
`endif

    esl_jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (busy),
        .tck      (tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= INIT_TLR;
            cnt   <= '0;
            tms   <= 1'b1;
            tdi   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            tms   <= tms_d;
            tdi   <= tdi_d;
        end
    end

    // State names follow the TAP state the target sits in during the TCK cycle;
    // RUN is the leading Run-Test/Idle cycle, UPDATE returns the target to idle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            INIT_TLR: if (fall_stb) begin
                if (cnt == 6'(TLR_CYCLES_C)) state_d = cmd_q.tlr ? RSP : IDLE;
                else cnt_d = cnt + 6'd1;
            end
            IDLE: if (cmd_valid) begin
                cnt_d = '0;
                if (cmd_tlr) state_d = INIT_TLR;
                else if (len_c == 6'd0) state_d = RSP;
                else state_d = RUN;
            end
            RUN:     if (fall_stb) state_d = SEL_DR;
            SEL_DR:  if (fall_stb) state_d = cmd_q.ir ? SEL_IR : CAPTURE;
            SEL_IR:  if (fall_stb) state_d = CAPTURE;
            CAPTURE: if (fall_stb) state_d = SHIFT;
            SHIFT: if (fall_stb) begin
                if (last_bit) state_d = EXIT1;
                else cnt_d = cnt + 6'd1;
            end
            EXIT1:   if (fall_stb) state_d = UPDATE;
            UPDATE:  if (fall_stb) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = INIT_TLR;
        endcase

        tms_d = 1'b0;
        tdi_d = 1'b0;
        unique case (state_d)
            INIT_TLR:   tms_d = (cnt_d < 6'(TLR_CYCLES_C));
            RUN, EXIT1: tms_d = 1'b1;
            SEL_DR:     tms_d = cmd_q.ir;
            SHIFT: begin
                tms_d = (cnt_d == cmd_q.len - 6'd1);
                tdi_d = dat_q[cnt_d];
            end
            default:    tms_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q <= '0;
            dat_q <= '0;
            cap_q <= '0;
        end else if (accept) begin
            cmd_q <= '{ir: cmd_ir, tlr: cmd_tlr, len: len_c};
            dat_q <= cmd_data;
            cap_q <= '0;
        end else if (state == SHIFT && rise_stb) begin
            cap_q[cnt] <= tdo;
        end
    end

endmodule

// File: tb/tb_esl_jtag_tap_master.sv
// Scoreboard bench for esl_jtag_tap_master with a loopback target model.
// Builds with or without ESL_JTAG_MASTER_TRST_EN.
module tb_esl_jtag_tap_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_ir = 1'b0;
    logic        cmd_tlr = 1'b0;
    logic [5:0]  cmd_len = '0;
    logic [37:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [37:0] rsp_data;
    logic        tck, tms, tdi, tdo, busy;
`ifdef ESL_JTAG_MASTER_TRST_EN
    logic        trst_n;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rises = 0;
    logic [37:0] exp_q[$];
    logic [1:0]  trace[$];
    int          rise_cyc[$];
    logic tgt_r = 1'b0;
    logic tdo_loop = 1'b0;
    logic tdo_one = 1'b0;

    esl_jtag_tap_master dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ir    (cmd_ir),
        .cmd_tlr   (cmd_tlr),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
`ifdef ESL_JTAG_MASTER_TRST_EN
        .trst_n    (trst_n),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Target: 1-bit register loops tdi back to tdo, tdo updates on falling tck.
    always @(posedge tck) tgt_r <= tdi;
    always @(negedge tck) tdo_loop <= tgt_r;
    assign tdo = tdo_one | tdo_loop;

    always @(posedge tck) begin
        trace.push_back({tms, tdi});
        rise_cyc.push_back(cyc);
        rises++;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [37:0] e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_unexpected: got %0h, required none", rsp_data);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e));
            end
        end
    end

    function automatic logic [63:0] tms_bits();
        logic [63:0] v = '0;
        foreach (trace[i]) if (i < 64) v[i] = trace[i][1];
        return v;
    endfunction

    function automatic logic [63:0] tdi_bits();
        logic [63:0] v = '0;
        foreach (trace[i]) if (i < 64) v[i] = trace[i][0];
        return v;
    endfunction

    task automatic send(input logic ir, input logic tlr,
                        input logic [5:0] len, input logic [37:0] data);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_ir    = ir;
        cmd_tlr   = tlr;
        cmd_len   = len;
        cmd_data  = data;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 3000);
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_accept: cmd_ready=%0b, required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 3000);
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: cmd_ready=%0b, required 1", cmd_ready);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tck"}, 64'(tck), 64'd0);
        chk({tag, "_tms"}, 64'(tms), 64'd1);
        chk({tag, "_tdi"}, 64'(tdi), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r0;
        int per;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        trace.delete();
        rise_cyc.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_idle();
        chk("init_tms", tms_bits(), 64'h1F);
        chk("init_len", 64'(trace.size()), 64'd6);
        per = (rise_cyc.size() > 1) ? rise_cyc[1] - rise_cyc[0] : 0;
        chk("tck_period", 64'(per), 64'd8);

        // DR scan, 32 bits through the loopback register
        trace.delete();
        exp_q.push_back(38'h00_2468_ACF0);
        send(1'b0, 1'b0, 6'd32, 38'h00_1234_5678);
        @(negedge clk);
        chk("dr_busy", 64'(busy), 64'd1);
        wait_idle();
        chk("dr_tms", tms_bits(), 64'hC_0000_0001);
        chk("dr_len", 64'(trace.size()), 64'd37);
        chk("dr_tdi", (tdi_bits() >> 3) & 64'hFFFF_FFFF, 64'h1234_5678);

        // IR scan, 2 bits, tdo tied high
        tdo_one = 1'b1;
        trace.delete();
        exp_q.push_back(38'h3);
        send(1'b1, 1'b0, 6'd2, 38'h2);
        wait_idle();
        chk("ir_tms", tms_bits(), 64'h63);
        chk("ir_len", 64'(trace.size()), 64'd8);
        chk("ir_tdi", (tdi_bits() >> 4) & 64'h3, 64'h2);
        tdo_one = 1'b0;

        // TLR command ignores the scan fields
        trace.delete();
        exp_q.push_back(38'h0);
        send(1'b1, 1'b1, 6'd20, 38'h3F_FFFF_FFFF);
        wait_idle();
        chk("tlr_tms", tms_bits(), 64'h1F);
        chk("tlr_len", 64'(trace.size()), 64'd6);

        // zero-length scan
        trace.delete();
        exp_q.push_back(38'h0);
        send(1'b0, 1'b0, 6'd0, 38'h155);
        @(negedge clk);
        chk("len0_rsp_valid", 64'(rsp_valid), 64'd1);
        wait_idle();
        chk("len0_tck", 64'(trace.size()), 64'd0);

        // over-length scan clamps to 38 bits
        trace.delete();
        exp_q.push_back(38'h30_0000_0002);
        send(1'b0, 1'b0, 6'd45, 38'h38_0000_0001);
        wait_idle();
        chk("len45_tms", tms_bits(), 64'h300_0000_0001);
        chk("len45_len", 64'(trace.size()), 64'd43);
        chk("len45_tdi", (tdi_bits() >> 3) & 64'h3F_FFFF_FFFF,
            64'h38_0000_0001);

        // response back-pressure with a second command waiting
        rsp_ready = 1'b0;
        trace.delete();
        exp_q.push_back(38'h4);
        send(1'b0, 1'b0, 6'd4, 38'hA);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 3000);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_ir    = 1'b0;
        cmd_tlr   = 1'b0;
        cmd_len   = 6'd3;
        cmd_data  = 38'h7;
        r0 = rises;
        repeat (20) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_data", 64'(rsp_data), 64'h4);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd0);
        end
        chk("bp_no_tck", 64'(rises - r0), 64'd0);
        exp_q.push_back(38'h6);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 3000);
        chk("bp_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle();

        // reset during shift bit 10 of a 38-bit scan
        r0 = rises;
        send(1'b0, 1'b0, 6'd38, 38'h2A_AAAA_AAAA);
        n = 0;
        do begin @(negedge clk); n++; end
        while ((rises - r0) < 14 && n < 3000);
        chk("mid_rises", 64'(rises - r0), 64'd14);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #1;
        trace.delete();
        rise_cyc.delete();
        reset_n = 1'b1;
        wait_idle();
        chk("mid_init_tms", tms_bits(), 64'h1F);
        chk("mid_init_len", 64'(trace.size()), 64'd6);

        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
